// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, constants and helpers for the binary-to-BCD converter
package bcd_pkg;

    // Converter sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Nibble shown on every digit when the value does not fit the display
    localparam logic [3:0] ERR_NIBBLE = 4'hE;

    // Largest value representable in the given number of BCD digits (10^digits - 1)
    function automatic logic [63:0] max_bcd_val(input int unsigned digits);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - combinational BCD digit corrector: adds 3 when the nibble is 5 or more
module bcd_add3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    // Pre-shift correction so the doubled digit carries into the next decade
    always_comb begin
        nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary-to-BCD converter with start/busy/done handshake
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int IN_W   = 27,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int                ACC_W    = 4 * DIGITS;
    localparam int                CNT_W    = $clog2(IN_W + 1);
    localparam logic [63:0]       MAX_VAL  = max_bcd_val(DIGITS);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    // Reject widths whose full range could overrun the accumulator in a way the
    // overflow flag would not explain
    if (IN_W < 1 || DIGITS < 1 || (DIGITS == 8 && IN_W > 27)) begin : g_bad_param
        $error("bin2bcd_seq: IN_W out of legal range for DIGITS");
    end

    state_t              state_q;
    logic [IN_W-1:0]     shreg_q;
    logic [ACC_W-1:0]    acc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_pend_q;
    logic [ACC_W-1:0]    bcd_q;
    logic                ovf_q;
    logic                done_q;
    logic                busy_q;

    logic [ACC_W-1:0]        acc_adj;
    logic [ACC_W+IN_W-1:0]   shift_cat;
    logic [ACC_W-1:0]        acc_d;
    logic [IN_W-1:0]         shreg_d;
    logic                    bin_ovf;

    // One corrector per digit, all applied in parallel before the shift
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i (acc_q[4*g +: 4]),
            .nib_o (acc_adj[4*g +: 4])
        );
    end

    // Next accumulator/shift-register pair; the bit leaving the top digit is
    // dropped, which only happens for values already flagged as overflow
    always_comb begin
        shift_cat = {acc_adj, shreg_q} << 1;
        acc_d     = shift_cat[ACC_W+IN_W-1:IN_W];
        shreg_d   = shift_cat[IN_W-1:0];
        bin_ovf   = ({{(64-IN_W){1'b0}}, bin} > MAX_VAL);
    end

    // Conversion sequencer with registered handshake and result outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        shreg_q    <= bin;
                        acc_q      <= '0;
                        cnt_q      <= CNT_LOAD;
                        ovf_pend_q <= bin_ovf;
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q   <= acc_d;
                    shreg_q <= shreg_d;
                    cnt_q   <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    bcd_q   <= ovf_pend_q ? {DIGITS{ERR_NIBBLE}} : acc_q;
                    ovf_q   <= ovf_pend_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign bcd      = bcd_q;

endmodule
